rr_burst_sched: RTL and testbench
=================================

// Module: rr_burst_sched
// PURPOSE
//   Round-robin scheduler that shares one single-ported resource between N requesters.
//   Each grant is a burst of 1..2^LEN_W beats, paced by the resource's ready signal.
//   Sits between requester ports and the shared resource mux; grant drives the mux select.
//   A masked/unmasked priority pick gives fairness; a burst FSM holds the grant until done.
// PARAMETERS
//   N      4   number of requesters (>=2)
//   LEN_W  4   width of per-requester burst length field (beats-1 encoding)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   req        in   N        request per requester; held until granted
//   req_len    in   N*LEN_W  beats-1 per requester, slice i = [i*LEN_W +: LEN_W]
//   rsrc_ready in   1        resource accepts the current beat this cycle
//   grant      out  N        one-hot registered grant, drives resource mux select
//   beat_last  out  1        current granted beat is the final beat of the burst
//   busy       out  1        burst in progress (state == BURST)
// BEHAVIOUR
//   Interface: one clock clk; reset rst is synchronous and active-high.
//   Reset values: grant=0, beat_last=0, busy=0, state=IDLE, beat_cnt=0, prio_mask=all ones.
//   FSM states: IDLE, BURST.
//   - IDLE: if |req, pick a winner W, register grant=onehot(W), load beat_cnt=req_len[W], go to BURST.
//     Otherwise stay in IDLE with grant=0.
//   - BURST, beat accepted = rsrc_ready & |grant:
//       beat_cnt!=0: beat_cnt decrements by 1.
//       beat_cnt==0: burst done; grant=0 and busy=0 next cycle; state=IDLE.
//       Then prio_mask = bits strictly above W; if W==N-1, prio_mask = all ones.
//   - Abort: req[W] low in BURST -> same as done on that edge, regardless of rsrc_ready.
//     Pointer still advances past W.
//   Winner pick:
//   - masked = req & prio_mask; if |masked pick lowest set bit of masked.
//   - Else pick lowest set bit of req.
//   Latency: req seen in IDLE at cycle t -> grant at t+1.
//   - Mandatory 1-cycle grant=0 gap between bursts; no back-to-back grants.
//   beat_last = busy & (beat_cnt==0), combinational from registers.
//   rsrc_ready low stalls the counter; the grant is held indefinitely.
//   req_len is sampled only at the grant edge; later changes are ignored for that burst.
//   Simultaneous done+new reqs: the new pick happens in the following IDLE cycle using the
//   updated mask.
//   Reset mid-burst: rst wins over all, outputs return to reset values next edge.
//   Invariants: grant is one-hot or zero; grant!=0 iff busy.
//   Starvation bound: a held request is granted within (N-1)*(2^LEN_W+1) ready cycles.
// STRUCTURE
//   Package arb_pkg:
//   - typedef enum logic {IDLE, BURST} sched_state_e
//   - function lowest_onehot(logic [N-1:0]) used by the pick logic
//   Sub-module prio_pick #(N): fixed-priority one-hot picker (lowest index wins).
//   - Instantiated twice: masked and unmasked request vectors.
//   Top: FSM, beat counter, prio_mask register, winner mux, output registers.
// TESTING
//   1 rst=1 two cycles with req=4'hF -> grant=0, busy=0, beat_last=0 throughout.
//   2 req=4'b0100, len[2]=0, ready=1 at cycle 1 -> grant=4'b0100 with beat_last=1 at
//     cycle 2; grant=0 at cycle 3.
//   3 req=4'hF held, all len=1, ready=1 -> grants 0,1,2,3,0 in order.
//     Each grant lasts 2 cycles, separated by a 1-cycle gap.
//   4 req[1], len=2, ready low for 3 cycles mid-burst -> grant held 6 cycles.
//     Exactly 3 accepted beats; beat_last only on the 3rd.
//   5 req[0] len=7; drop req[0] after 2 beats -> grant=0 next cycle.
//     Next pick with req=4'b0011 goes to requester 1.
//   6 rst pulse during requester 2's burst, req=4'hF -> grant=0 next cycle.
//     First grant after rst release is 4'b0001.

Source files
------------

// File: rtl/arb_pkg.sv
// +----------------------------------------------------------------------+
// | arb_pkg : shared types and helpers for the round-robin burst sched   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam int ARB_MAX_N = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  // Two's-complement trick isolates the lowest set bit.
  function automatic logic [ARB_MAX_N-1:0] lowest_onehot(input logic [ARB_MAX_N-1:0] v);
    return v & (~v + {{(ARB_MAX_N-1){1'b0}}, 1'b1});
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// +----------------------------------------------------------------------+
// | prio_pick : fixed-priority one-hot picker, lowest index wins         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module prio_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot
);

  logic [ARB_MAX_N-1:0] req_ext;
  logic [ARB_MAX_N-1:0] pick_ext;
  logic [ARB_MAX_N-1:0] unused_pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign pick_ext    = lowest_onehot(req_ext);
  assign onehot      = pick_ext[N-1:0];
  assign unused_pick = pick_ext;

endmodule

`default_nettype wire

// File: rtl/rr_burst_sched.sv
// +----------------------------------------------------------------------+
// | rr_burst_sched : round-robin scheduler granting paced beat bursts    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_burst_sched
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*LEN_W-1:0] req_len,
  input  logic               rsrc_ready,
  output logic [N-1:0]       grant,
  output logic               beat_last,
  output logic               busy
);

  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ONE_CNT = {{(LEN_W-1){1'b0}}, 1'b1};

  sched_state_e     state;
  logic [LEN_W-1:0] beat_cnt;
  logic [N-1:0]     prio_mask;

  logic [N-1:0]     masked_req;
  logic [N-1:0]     masked_oh;
  logic [N-1:0]     plain_oh;
  logic [N-1:0]     winner;
  logic [LEN_W-1:0] winner_len;
  logic [N-1:0]     next_mask;
  logic             accepted;
  logic             aborted;
  logic             last_cnt;

  assign masked_req = req & prio_mask;

  prio_pick #(.N(N)) u_pick_masked (
    .req    (masked_req),
    .onehot (masked_oh)
  );

  prio_pick #(.N(N)) u_pick_plain (
    .req    (req),
    .onehot (plain_oh)
  );

  assign winner = (|masked_req) ? masked_oh : plain_oh;

  always_comb begin
    winner_len = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) winner_len = winner_len | req_len[i*LEN_W +: LEN_W];
    end
  end

  // Mask keeps only requesters strictly above the current owner; wraps to all when owner is top.
  assign next_mask = grant[N-1] ? '1 : ~(grant | (grant - ONE_N));

  assign accepted  = rsrc_ready & (|grant);
  assign aborted   = ~(|(grant & req));
  assign last_cnt  = (beat_cnt == '0);
  assign beat_last = busy & last_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
      prio_mask <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= winner;
            beat_cnt <= winner_len;
            busy     <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (aborted || (accepted && last_cnt)) begin
            grant     <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
            prio_mask <= next_mask;
          end else if (accepted) begin
            beat_cnt <= beat_cnt - ONE_CNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_burst_sched.sv
// +----------------------------------------------------------------------+
// | tb_rr_burst_sched : directed + randomized bench with rotation model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rr_burst_sched;

  localparam int N     = 4;
  localparam int LEN_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*LEN_W-1:0] req_len;
  logic               rsrc_ready;
  logic [N-1:0]       grant;
  logic               beat_last;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference: owner, beats remaining, last served requester.
  bit m_busy;
  int m_owner;
  int m_rem;
  int m_last;

  always #5 clk = ~clk;

  rr_burst_sched #(.N(N), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (req_len),
    .rsrc_ready (rsrc_ready),
    .grant      (grant),
    .beat_last  (beat_last),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Rotating search starting just after the last served requester.
  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0;
      m_rem  = 0;
      m_last = N - 1;
    end else if (!m_busy) begin
      if (|req) begin
        m_owner = rr_pick(req);
        m_busy  = 1'b1;
        m_rem   = int'(req_len[m_owner*LEN_W +: LEN_W]);
      end
    end else if (!req[m_owner] || (rsrc_ready && m_rem == 0)) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (rsrc_ready) begin
      m_rem--;
    end
  endtask

  task automatic cycle(input string tag);
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    check({tag, "_grant"}, 32'(grant), 32'(eg));
    check({tag, "_busy"}, 32'(busy), 32'(m_busy));
    check({tag, "_last"}, 32'(beat_last), 32'(m_busy && m_rem == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cycle("rst");
    rst = 1'b0;
  endtask

  logic [N-1:0] exp_seq [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                 4'b0001};
  bit ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int gcycles, beats, last_hits, waited;
    bit served [N];

    // 1: reset held with all requests pending
    rst = 1'b1; req = 4'hF; req_len = '0; rsrc_ready = 1'b1;
    m_busy = 1'b0; m_owner = 0; m_rem = 0; m_last = N - 1;
    cycle("t1a");
    cycle("t1b");
    check("t1_grant_zero", 32'(grant), 32'd0);
    rst = 1'b0; req = '0;
    cycle("t1c");

    // 2: single-beat burst
    req = 4'b0100; req_len = '0; rsrc_ready = 1'b1;
    cycle("t2a");
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_beat_last", 32'(beat_last), 32'd1);
    req = '0;
    cycle("t2b");
    check("t2_grant_off", 32'(grant), 32'd0);

    // 3: fair rotation with 2-beat bursts
    do_reset();
    req = 4'hF; req_len = 16'h1111; rsrc_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle("t3");
      check($sformatf("t3_seq%0d", i), 32'(grant), 32'(exp_seq[i]));
    end
    req = '0;
    cycle("t3z");

    // 4: stalled 3-beat burst
    do_reset();
    req = 4'b0010; req_len = 16'h0020; rsrc_ready = 1'b1;
    cycle("t4a");
    gcycles = 0; beats = 0; last_hits = 0;
    for (int i = 0; i < 6; i++) begin
      rsrc_ready = ready_pat[i];
      if (grant != '0) begin
        gcycles++;
        if (rsrc_ready) begin
          beats++;
          if (beat_last) begin
            last_hits++;
            check("t4_last_on_third", 32'(beats), 32'd3);
          end
        end
      end
      cycle("t4");
    end
    req = '0;
    check("t4_grant_cycles", 32'(gcycles), 32'd6);
    check("t4_beats", 32'(beats), 32'd3);
    check("t4_last_hits", 32'(last_hits), 32'd1);
    cycle("t4z");

    // 5: abort mid-burst, pointer still advances
    do_reset();
    req = 4'b0001; req_len = 16'h0007; rsrc_ready = 1'b1;
    cycle("t5a");
    cycle("t5b");
    cycle("t5c");
    req = '0;
    cycle("t5d");
    check("t5_abort", 32'(grant), 32'd0);
    req = 4'b0011;
    cycle("t5e");
    check("t5_next_pick", 32'(grant), 32'h2);
    req = '0;
    cycle("t5f");

    // 6: reset in the middle of requester 2's burst
    do_reset();
    req = 4'hF; req_len = 16'h3333; rsrc_ready = 1'b1;
    waited = 0;
    while (grant != 4'b0100 && waited < 40) begin
      cycle("t6w");
      waited++;
    end
    check("t6_reached_r2", 32'(grant), 32'h4);
    rst = 1'b1;
    cycle("t6r");
    check("t6_rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    cycle("t6p");
    check("t6_first_after_rst", 32'(grant), 32'h1);
    req = '0;
    cycle("t6z");

    // Randomized traffic against the rotation model
    do_reset();
    for (int i = 0; i < N; i++) served[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_busy && m_owner == i) served[i] = 1'b1;
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (m_busy && m_owner == i) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if (served[i]) begin
          served[i] = 1'b0;
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end
        req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 5));
      end
      rsrc_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      else rst = 1'b0;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
